regfile_wr_arbiter: RTL and testbench
=====================================

REGFILE_WR_ARBITER -- requirements
Module: regfile_wr_arbiter

Interface
REQ-001 Parameter: DATA_W, 32, register data width.
REQ-002 Parameter: ADDR_W, 5, register address width.
REQ-003 Parameter: CNT_W, 8, contention counter width.
REQ-004 clk  input  1  single clock; all state on rising edge.
REQ-005 reset  input  1  reset, asynchronous, active-low (0 = reset asserted).
REQ-006 freeze  input  1  pipeline stall; blocks all grants while 1.
REQ-007 req0_valid / req1_valid  input  1 each  write request from requester 0 (ALU writeback) / 1 (load writeback).
REQ-008 req0_addr / req1_addr  input  ADDR_W each  target register.
REQ-009 req0_data / req1_data  input  DATA_W each  write data.
REQ-010 req0_ready / req1_ready  output  1 each  request accepted this cycle.
REQ-011 RsAddr / RtAddr  input  ADDR_W each  read addresses currently presented to the register file.
REQ-012 rs_hazard / rt_hazard  output  1 each  read address has a write in flight.
REQ-013 regWriteEn  output  1  register file write enable.
REQ-014 regWriteAddr  output  ADDR_W  register file write address.
REQ-015 regWriteData  output  DATA_W  register file write data.
REQ-016 contend_cnt  output  CNT_W  saturating count of cycles with both requests valid.

Function
REQ-017 Handshake: a transfer on port n SHALL occur when reqn_valid and reqn_ready are both 1 at a rising edge; at most one transfer per cycle.
REQ-018 reqn_ready SHALL be combinational: 1 only if port n is granted and freeze=0; ready SHALL NOT depend on any other port's ready.
REQ-019 Grant with one valid request: that port. Grant with both valid: the port not granted on the most recent transfer (round-robin).
REQ-020 Round-robin pointer SHALL update only on a transfer; a cycle with freeze=1 or no valid request SHALL leave it unchanged.
REQ-021 Latency: a transfer at edge k SHALL drive regWriteEn=1, regWriteAddr and regWriteData from the accepted request during cycle k+1, for exactly one cycle.
REQ-022 In any cycle following an edge with no transfer, regWriteEn SHALL be 0; regWriteAddr and regWriteData SHALL hold their last values.
REQ-023 A transfer with addr=0 SHALL complete the handshake normally but SHALL leave regWriteEn=0 in the following cycle ($0 is never written).
REQ-024 rs_hazard SHALL be combinational: 1 if RsAddr!=0 and either regWriteEn=1 with regWriteAddr==RsAddr, or any reqn_valid=1 with reqn_addr==RsAddr. rt_hazard SHALL be identical using RtAddr.
REQ-025 contend_cnt SHALL increment on each edge where req0_valid=1 and req1_valid=1, including cycles with freeze=1, and SHALL saturate at all-ones.
REQ-026 freeze=1 coincident with both requests valid: no transfer; the counter still increments; the grant order is preserved after release.
REQ-027 Requesters SHALL hold valid, addr and data stable until the transfer completes; the arbiter does not need to tolerate a withdrawn request.

Reset
REQ-028 While reset=0 (asynchronous): regWriteEn=0, regWriteAddr=0, regWriteData=0, contend_cnt=0, and the round-robin pointer is set so that port 0 wins the first contention.
REQ-029 Reset asserted mid-operation SHALL discard any pending write; regWriteEn SHALL be 0 in the first cycle after release.
REQ-030 Outputs derived combinationally from inputs (ready, hazard) SHALL additionally be forced to 0 while reset=0.

Structure
REQ-031 DATA_W, ADDR_W and the REG_ZERO address constant SHALL reside in a shared package regfile_pkg used by the RegFile and this block.
REQ-032 Two-way round-robin grant logic plus pointer SHALL be a sub-module rr_arb2 (inputs: clk, reset, req[1:0], advance; output: gnt[1:0], one-hot or zero).
REQ-033 All other logic, including the output write stage, hazard compare and counter, SHALL be in regfile_wr_arbiter.

Verification
REQ-034 Reset release, req0 only (addr 3, data 0x5aa5) -> req0_ready=1 at the same cycle; next cycle regWriteEn=1, addr 3, data 0x5aa5; the cycle after, regWriteEn=0.
REQ-035 Both valid for 4 consecutive cycles (req0 addr 1, req1 addr 2) -> grants 0,1,0,1 in order; contend_cnt=4.
REQ-036 Both valid, freeze=1 for 3 cycles then 0 -> no ready for 3 cycles, contend_cnt=3; first grant after release is port 0.
REQ-037 req1 addr 0, data 0xFFFFFFFF -> req1_ready=1; regWriteEn remains 0.
REQ-038 Output stage writing addr 5 with RsAddr=5 and RtAddr=0 -> rs_hazard=1, rt_hazard=0; RsAddr=7 with req0_valid, addr 7 -> rs_hazard=1.
REQ-039 Hold both valid for 300 cycles -> contend_cnt=255 and stays at 255; reset pulse mid-stream -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/regfile_pkg.sv
// regfile_pkg: widths and constants shared by the register file and its write arbiter.
package regfile_pkg;
   localparam int DATA_W = 32;
   localparam int ADDR_W = 5;
   localparam int CNT_W  = 8;
   localparam logic [ADDR_W-1:0] REG_ZERO = '0;
   typedef enum logic {PORT0 = 1'b0, PORT1 = 1'b1} port_e;
endpackage

// File: rtl/regfile_wr_arbiter_if.sv
// regfile_wr_arbiter_if: requester, read-address and register-file-write signals of the arbiter.
interface regfile_wr_arbiter_if;
   import regfile_pkg::*;
   logic              freeze;
   logic              req0_valid, req1_valid;
   logic [ADDR_W-1:0] req0_addr, req1_addr;
   logic [DATA_W-1:0] req0_data, req1_data;
   logic              req0_ready, req1_ready;
   logic [ADDR_W-1:0] RsAddr, RtAddr;
   logic              rs_hazard, rt_hazard;
   logic              regWriteEn;
   logic [ADDR_W-1:0] regWriteAddr;
   logic [DATA_W-1:0] regWriteData;
   logic [CNT_W-1:0]  contend_cnt;
   modport master (
      output freeze, req0_valid, req1_valid, req0_addr, req1_addr, req0_data, req1_data, RsAddr, RtAddr,
      input  req0_ready, req1_ready, rs_hazard, rt_hazard, regWriteEn, regWriteAddr, regWriteData, contend_cnt
   );
   modport slave (
      input  freeze, req0_valid, req1_valid, req0_addr, req1_addr, req0_data, req1_data, RsAddr, RtAddr,
      output req0_ready, req1_ready, rs_hazard, rt_hazard, regWriteEn, regWriteAddr, regWriteData, contend_cnt
   );
endinterface

// File: rtl/regfile_wr_arbiter_rr_arb2.sv
// rr_arb2: two-way round-robin grant; the pointer remembers the last port that transferred.
module rr_arb2
   import regfile_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic [1:0] req,
   input  logic       advance,
   output logic [1:0] gnt
);
   port_e last_q, last_d;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) last_q <= PORT1;
      else        last_q <= last_d;
   end
   always_comb begin
      gnt    = (&req) ? ((last_q == PORT1) ? 2'b01 : 2'b10) : req;
      last_d = advance ? (gnt[1] ? PORT1 : PORT0) : last_q;
   end
endmodule

// File: rtl/regfile_wr_arbiter.sv
// regfile_wr_arbiter: arbitrates ALU and load writebacks onto one register-file write port,
// with read-hazard detection and a saturating contention counter.
module regfile_wr_arbiter
   import regfile_pkg::*;
(
   input  logic                 clk,
   input  logic                 rst_n,
   regfile_wr_arbiter_if.slave  bus
);
   logic [1:0]        gnt;
   logic              xfer0, xfer1, both;
   logic              we_q, we_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] data_q, data_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;

   function automatic logic hit(input logic [ADDR_W-1:0] a);
      return (a != REG_ZERO) &&
             ((we_q && addr_q == a) ||
              (bus.req0_valid && bus.req0_addr == a) ||
              (bus.req1_valid && bus.req1_addr == a));
   endfunction

   rr_arb2 u_arb (
      .clk     (clk),
      .rst_n   (rst_n),
      .req     ({bus.req1_valid, bus.req0_valid}),
      .advance (xfer0 | xfer1),
      .gnt     (gnt)
   );

   assign bus.req0_ready   = gnt[0] & ~bus.freeze & rst_n;
   assign bus.req1_ready   = gnt[1] & ~bus.freeze & rst_n;
   assign xfer0            = bus.req0_valid & bus.req0_ready;
   assign xfer1            = bus.req1_valid & bus.req1_ready;
   assign both             = bus.req0_valid & bus.req1_valid;
   assign bus.rs_hazard    = hit(bus.RsAddr) & rst_n;
   assign bus.rt_hazard    = hit(bus.RtAddr) & rst_n;
   assign bus.regWriteEn   = we_q;
   assign bus.regWriteAddr = addr_q;
   assign bus.regWriteData = data_q;
   assign bus.contend_cnt  = cnt_q;

   // Transfers to $0 still move the address/data registers but never raise the enable.
   always_comb begin
      we_d   = 1'b0;
      addr_d = addr_q;
      data_d = data_q;
      if (xfer0) begin
         we_d   = bus.req0_addr != REG_ZERO;
         addr_d = bus.req0_addr;
         data_d = bus.req0_data;
      end else if (xfer1) begin
         we_d   = bus.req1_addr != REG_ZERO;
         addr_d = bus.req1_addr;
         data_d = bus.req1_data;
      end
      cnt_d = (both && !(&cnt_q)) ? cnt_q + CNT_W'(1) : cnt_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         we_q   <= 1'b0;
         addr_q <= '0;
         data_q <= '0;
         cnt_q  <= '0;
      end else begin
         we_q   <= we_d;
         addr_q <= addr_d;
         data_q <= data_d;
         cnt_q  <= cnt_d;
      end
   end
endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// tb_regfile_wr_arbiter: directed stimulus with a write-port scoreboard and a decoupled monitor.
module tb_regfile_wr_arbiter;
   import regfile_pkg::*;

   typedef struct packed {
      logic [ADDR_W-1:0] a;
      logic [DATA_W-1:0] d;
   } wr_t;

   logic clk = 1'b0;
   logic rst_n;
   int   checks = 0;
   int   failures = 0;
   wr_t  sb[$];

   always #5 clk = ~clk;

   regfile_wr_arbiter_if bus ();

   regfile_wr_arbiter dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
      end
   endtask

   // Monitor: every write the DUT presents must match the oldest expected write.
   always @(negedge clk) begin
      if (rst_n === 1'b1 && bus.regWriteEn === 1'b1) begin
         checks++;
         if (sb.size() == 0) begin
            failures++;
            $display("FAIL wr_unexpected actual addr=%0h data=%0h required no write t=%0t",
                     bus.regWriteAddr, bus.regWriteData, $time);
         end else begin
            wr_t e;
            e = sb.pop_front();
            if (bus.regWriteAddr !== e.a || bus.regWriteData !== e.d) begin
               failures++;
               $display("FAIL wr_data actual addr=%0h data=%0h required addr=%0h data=%0h t=%0t",
                        bus.regWriteAddr, bus.regWriteData, e.a, e.d, $time);
            end
         end
      end
   end

   task automatic idle();
      bus.req0_valid = 1'b0;
      bus.req1_valid = 1'b0;
      bus.freeze     = 1'b0;
   endtask

   task automatic adv();
      @(posedge clk);
      #1;
   endtask

   // Check readies mid-cycle and record the write each expected transfer should produce.
   task automatic cyc(input logic e0, input logic e1);
      @(negedge clk);
      chk("req0_ready", bus.req0_ready, e0);
      chk("req1_ready", bus.req1_ready, e1);
      if (e0 && bus.req0_addr != REG_ZERO) sb.push_back({bus.req0_addr, bus.req0_data});
      if (e1 && bus.req1_addr != REG_ZERO) sb.push_back({bus.req1_addr, bus.req1_data});
   endtask

   task automatic do_reset(input bit expect_drained);
      if (expect_drained) chk("sb_drained", sb.size(), 0);
      rst_n = 1'b0;
      #1;
      chk("rst_ready0", bus.req0_ready, 0);
      chk("rst_ready1", bus.req1_ready, 0);
      chk("rst_we", bus.regWriteEn, 0);
      chk("rst_addr", bus.regWriteAddr, 0);
      chk("rst_data", bus.regWriteData, 0);
      chk("rst_cnt", bus.contend_cnt, 0);
      chk("rst_rs_haz", bus.rs_hazard, 0);
      chk("rst_rt_haz", bus.rt_hazard, 0);
      sb.delete();
      repeat (2) adv();
      rst_n = 1'b1;
   endtask

   initial begin
      logic [DATA_W-1:0] d0, d1;
      rst_n = 1'b1;
      idle();
      bus.req0_addr = '0; bus.req1_addr = '0;
      bus.req0_data = '0; bus.req1_data = '0;
      bus.RsAddr = '0; bus.RtAddr = '0;
      adv();
      // Reset with a matching valid request present: ready and hazards stay forced low.
      bus.req0_valid = 1'b1; bus.req0_addr = 5'd3; bus.req0_data = 32'h5aa5;
      bus.RsAddr = 5'd3; bus.RtAddr = 5'd3;
      do_reset(1'b1);
      bus.RsAddr = '0; bus.RtAddr = '0;
      cyc(1, 0);
      adv();
      idle();
      cyc(0, 0);
      chk("single_we_k1", bus.regWriteEn, 1);
      adv();
      cyc(0, 0);
      chk("single_we_k2", bus.regWriteEn, 0);
      chk("single_hold_addr", bus.regWriteAddr, 3);
      chk("single_hold_data", bus.regWriteData, 32'h5aa5);
      adv();

      // Four cycles of contention: grants alternate 0,1,0,1.
      do_reset(1'b1);
      d0 = 32'h100; d1 = 32'h200;
      bus.req0_valid = 1'b1; bus.req0_addr = 5'd1;
      bus.req1_valid = 1'b1; bus.req1_addr = 5'd2;
      for (int i = 0; i < 4; i++) begin
         bus.req0_data = d0; bus.req1_data = d1;
         cyc(i % 2 == 0, i % 2 == 1);
         adv();
         if (i % 2 == 0) d0++; else d1++;
      end
      idle();
      cyc(0, 0);
      chk("rr_cnt4", bus.contend_cnt, 4);
      adv();
      cyc(0, 0);
      chk("rr_cnt_hold", bus.contend_cnt, 4);
      chk("rr_we_off", bus.regWriteEn, 0);
      adv();

      // Freeze during contention: no grants, counter runs, order kept.
      do_reset(1'b1);
      bus.req0_valid = 1'b1; bus.req0_addr = 5'd1; bus.req0_data = 32'h11;
      bus.req1_valid = 1'b1; bus.req1_addr = 5'd2; bus.req1_data = 32'h22;
      bus.freeze = 1'b1;
      repeat (3) begin
         cyc(0, 0);
         adv();
      end
      bus.freeze = 1'b0;
      cyc(1, 0);
      chk("frz_cnt3", bus.contend_cnt, 3);
      adv();
      cyc(0, 1);
      chk("frz_cnt4", bus.contend_cnt, 4);
      adv();
      idle();
      cyc(0, 0);
      chk("frz_cnt5", bus.contend_cnt, 5);
      adv();

      // Write to $0: handshake completes, no enable.
      bus.req1_valid = 1'b1; bus.req1_addr = 5'd0; bus.req1_data = 32'hffffffff;
      cyc(0, 1);
      adv();
      idle();
      cyc(0, 0);
      chk("zero_we", bus.regWriteEn, 0);
      adv();

      // Hazards from the output stage and from a pending request.
      bus.req0_valid = 1'b1; bus.req0_addr = 5'd5; bus.req0_data = 32'h55;
      cyc(1, 0);
      adv();
      idle();
      bus.RsAddr = 5'd5; bus.RtAddr = 5'd0;
      cyc(0, 0);
      chk("haz_rs_wr", bus.rs_hazard, 1);
      chk("haz_rt_zero", bus.rt_hazard, 0);
      adv();
      bus.RsAddr = 5'd7; bus.RtAddr = 5'd9;
      bus.req0_valid = 1'b1; bus.req0_addr = 5'd7; bus.req0_data = 32'h77;
      cyc(1, 0);
      chk("haz_rs_req", bus.rs_hazard, 1);
      chk("haz_rt_miss", bus.rt_hazard, 0);
      adv();
      idle();
      bus.RsAddr = '0; bus.RtAddr = '0;
      cyc(0, 0);
      adv();

      // Long contention: counter saturates at 255, then a mid-stream reset.
      do_reset(1'b1);
      bus.req0_valid = 1'b1; bus.req0_addr = 5'd1; bus.req0_data = 32'haaaa0001;
      bus.req1_valid = 1'b1; bus.req1_addr = 5'd2; bus.req1_data = 32'hbbbb0002;
      for (int i = 0; i < 300; i++) begin
         cyc(i % 2 == 0, i % 2 == 1);
         adv();
      end
      cyc(1, 0);
      chk("sat_cnt", bus.contend_cnt, 255);
      adv();
      cyc(0, 1);
      chk("sat_cnt_hold", bus.contend_cnt, 255);
      adv();
      do_reset(1'b0);
      cyc(1, 0);
      chk("post_rst_we", bus.regWriteEn, 0);
      adv();
      idle();
      cyc(0, 0);
      adv();
      cyc(0, 0);
      chk("sb_final", sb.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
